// File: rtl/tdm_demux4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux4_if
//   Bundles the serial input, the per-lane view and the word valid/ready
//   output of the TDM demultiplexer.
//
//   master : upstream source / consumer side (drives din, din_valid, sel,
//            word_ready; observes the rest)
//   slave  : the demultiplexer (tdm_demux4)
//
//   din        serial data bit
//   din_valid  din/sel qualify this cycle
//   sel        lane index of din
//   lane_q     last bit received on each lane
//   word       assembled frame, word[i] received with sel=i
//   word_valid word is available
//   word_ready consumer accepts word
//   seq_err    one-cycle pulse on an out-of-order lane index
//   overrun    sticky, a completed frame was dropped
// ---------------------------------------------------------------------------
interface tdm_demux4_if #(
   parameter int LANES = 4,
   parameter int SEL_W = $clog2(LANES)
);
   logic             din;
   logic             din_valid;
   logic [SEL_W-1:0] sel;
   logic [LANES-1:0] lane_q;
   logic [LANES-1:0] word;
   logic             word_valid;
   logic             word_ready;
   logic             seq_err;
   logic             overrun;

   modport master (
      output din, din_valid, sel, word_ready,
      input  lane_q, word, word_valid, seq_err, overrun
   );

   modport slave (
      input  din, din_valid, sel, word_ready,
      output lane_q, word, word_valid, seq_err, overrun
   );
endinterface

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//   Receive end of the LANES:1 bit-select mux path. Each cycle a qualified
//   serial bit arrives tagged with its lane select; it is demultiplexed into
//   its lane register and, when lanes arrive in order 0..LANES-1, the bits
//   are reassembled into a word presented on a valid/ready output.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    tdm_demux4_if.slave (din/din_valid/sel/word_ready in;
//            lane_q/word/word_valid/seq_err/overrun out)
// ---------------------------------------------------------------------------

// One lane of the demux: holds the last bit seen with its select.
module tdm_demux4_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic we,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= 1'b0;
      else if (we) q <= d;
   end
endmodule

module tdm_demux4 #(
   parameter int LANES = 4,
   parameter int SEL_W = $clog2(LANES)
) (
   input  logic         clk,
   input  logic         rst_n,
   tdm_demux4_if.slave  bus
);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t             state;
   logic [SEL_W-1:0]   exp_idx;
   // Bits 0..LANES-2 of the frame in progress; the last bit goes straight
   // into the output word on the completing cycle.
   logic [LANES-2:0]   asm_buf;
   logic [LANES-1:0]   lane_q;
   logic [LANES-1:0]   word;
   logic               word_valid;
   logic               seq_err;
   logic               overrun;

   logic               in_order;
   logic               complete;
   logic               can_take;
   logic [LANES-1:0]   frame_word;

   // ---------------- lane demux ----------------
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         tdm_demux4_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bus.din_valid && (bus.sel == SEL_W'(gi))),
            .d     (bus.din),
            .q     (lane_q[gi])
         );
      end
   endgenerate

   // ---------------- frame assembly ----------------
   assign in_order   = bus.din_valid && (state == COLLECT) && (bus.sel == exp_idx);
   assign complete   = in_order && (exp_idx == LAST);
   // A finished frame is only taken if the output slot is free or being
   // emptied in this same cycle; otherwise it is dropped.
   assign can_take   = !word_valid || bus.word_ready;
   assign frame_word = {bus.din, asm_buf};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         exp_idx    <= '0;
         asm_buf    <= '0;
         word       <= '0;
         word_valid <= 1'b0;
         seq_err    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         seq_err <= 1'b0;

         // output slot drains on handshake unless refilled below
         if (word_valid && bus.word_ready)
            word_valid <= 1'b0;

         if (bus.din_valid) begin
            case (state)
               IDLE: begin
                  // Bits with sel!=0 are ignored until the stream aligns.
                  if (bus.sel == '0) begin
                     asm_buf[0] <= bus.din;
                     exp_idx    <= SEL_W'(1);
                     state      <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (complete) begin
                     if (can_take) begin
                        word       <= frame_word;
                        word_valid <= 1'b1;
                     end else begin
                        overrun    <= 1'b1;
                     end
                     exp_idx <= '0;
                     state   <= IDLE;
                  end else if (in_order) begin
                     for (int i = 0; i < LANES - 1; i++)
                        if (exp_idx == SEL_W'(i)) asm_buf[i] <= bus.din;
                     exp_idx <= exp_idx + SEL_W'(1);
                  end else begin
                     // Out-of-order: drop the partial frame; a sel=0 bit
                     // immediately re-anchors a new one.
                     seq_err <= 1'b1;
                     if (bus.sel == '0) begin
                        asm_buf[0] <= bus.din;
                        exp_idx    <= SEL_W'(1);
                     end else begin
                        exp_idx    <= '0;
                        state      <= IDLE;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  exp_idx <= '0;
               end
            endcase
         end
      end
   end

   assign bus.lane_q     = lane_q;
   assign bus.word       = word;
   assign bus.word_valid = word_valid;
   assign bus.seq_err    = seq_err;
   assign bus.overrun    = overrun;
endmodule
